// File: rtl/instr_fetch_mem.sv
// Loadable instruction memory with a one-deep registered fetch response stage.
// Optional IMEM_PARITY_EN adds an even-parity bit per word and the resp_perr output.
module instr_fetch_mem #(
   parameter int unsigned              ADDR_WIDTH = 8,
   parameter int unsigned              DATA_WIDTH = 9,
   parameter logic [DATA_WIDTH-1:0]    NOP_WORD   = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load_start,
   input  logic                  load_valid,
   input  logic [DATA_WIDTH-1:0] load_data,
   input  logic                  load_last,
   output logic                  load_ready,
   output logic [ADDR_WIDTH:0]   prog_len,
   input  logic                  req_valid,
   input  logic [ADDR_WIDTH-1:0] req_pc,
   output logic                  req_ready,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_instr,
   output logic                  resp_oor,
`ifdef IMEM_PARITY_EN
   output logic                  resp_perr,
`endif
   input  logic                  resp_ready,
   output logic                  state_run
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
   localparam int unsigned PW    = ADDR_WIDTH + 1;
`ifdef IMEM_PARITY_EN
   localparam int unsigned MW    = DATA_WIDTH + 1;
`else
   localparam int unsigned MW    = DATA_WIDTH;
`endif

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2
   } state_t;

   state_t              state;
   logic [PW-1:0]       wr_ptr;
   logic [MW-1:0]       mem [DEPTH];

   logic                load_fire_c;
   logic                load_at_end_c;
   logic                req_fire_c;
   logic                in_range_c;
   logic [MW-1:0]       wr_word_c;
   logic [MW-1:0]       rd_word_c;

   assign load_fire_c   = load_valid && load_ready;
   assign load_at_end_c = (wr_ptr == PW'(DEPTH - 1));
   assign req_ready     = state_run && (!resp_valid || resp_ready);
   assign req_fire_c    = req_valid && req_ready;
   assign in_range_c    = (PW'(req_pc) < prog_len);
   assign rd_word_c     = mem[req_pc];

`ifdef IMEM_PARITY_EN
   assign wr_word_c = {^load_data, load_data};
`else
   assign wr_word_c = load_data;
`endif

   // Storage array has no reset; stale words are masked by the prog_len bound.
   always_ff @(posedge clk) begin
      if (load_fire_c) begin
         mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_word_c;
      end
   end

   // Control FSM, load pointer and registered response stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         wr_ptr     <= '0;
         prog_len   <= '0;
         load_ready <= 1'b0;
         state_run  <= 1'b0;
         resp_valid <= 1'b0;
         resp_instr <= '0;
         resp_oor   <= 1'b0;
`ifdef IMEM_PARITY_EN
         resp_perr  <= 1'b0;
`endif
      end else begin
         unique case (state)
            S_IDLE: begin
               if (load_start) begin
                  state      <= S_LOAD;
                  wr_ptr     <= '0;
                  prog_len   <= '0;
                  load_ready <= 1'b1;
               end
            end

            S_LOAD: begin
               if (load_fire_c) begin
                  prog_len <= prog_len + PW'(1);
                  // Pointer parks on the last address rather than wrapping.
                  if (!load_at_end_c) begin
                     wr_ptr <= wr_ptr + PW'(1);
                  end
                  if (load_last || load_at_end_c) begin
                     state      <= S_RUN;
                     load_ready <= 1'b0;
                     state_run  <= 1'b1;
                  end
               end
            end

            S_RUN: begin
               if (load_start) begin
                  state      <= S_LOAD;
                  wr_ptr     <= '0;
                  prog_len   <= '0;
                  load_ready <= 1'b1;
                  state_run  <= 1'b0;
                  resp_valid <= 1'b0;
`ifdef IMEM_PARITY_EN
                  resp_perr  <= 1'b0;
`endif
               end else if (req_fire_c) begin
                  resp_valid <= 1'b1;
                  resp_oor   <= !in_range_c;
                  resp_instr <= in_range_c ? rd_word_c[DATA_WIDTH-1:0] : NOP_WORD;
`ifdef IMEM_PARITY_EN
                  resp_perr  <= in_range_c && (^rd_word_c);
`endif
               end else if (resp_ready) begin
                  resp_valid <= 1'b0;
`ifdef IMEM_PARITY_EN
                  resp_perr  <= 1'b0;
`endif
               end
            end

            default: begin
               state      <= S_IDLE;
               load_ready <= 1'b0;
               state_run  <= 1'b0;
               resp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Self-checking bench for instr_fetch_mem against a word-array/handshake reference model.
module tb_instr_fetch_mem;

   localparam int unsigned AW    = 8;
   localparam int unsigned DW    = 9;
   localparam int unsigned DEPTH = 256;
   localparam logic [DW-1:0] NOP = '0;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          load_start, load_valid, load_last;
   logic [DW-1:0] load_data;
   logic          load_ready;
   logic [AW:0]   prog_len;
   logic          req_valid;
   logic [AW-1:0] req_pc;
   logic          req_ready;
   logic          resp_valid;
   logic [DW-1:0] resp_instr;
   logic          resp_oor;
   logic          resp_ready;
   logic          state_run;
`ifdef IMEM_PARITY_EN
   logic          resp_perr;
`endif

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] model_mem [DEPTH];
   int            model_len = 0;
   logic [DW-1:0] load_q [$];

   instr_fetch_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NOP_WORD(NOP)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_start (load_start),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_last  (load_last),
      .load_ready (load_ready),
      .prog_len   (prog_len),
      .req_valid  (req_valid),
      .req_pc     (req_pc),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_instr (resp_instr),
      .resp_oor   (resp_oor),
`ifdef IMEM_PARITY_EN
      .resp_perr  (resp_perr),
`endif
      .resp_ready (resp_ready),
      .state_run  (state_run)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] exp_instr(input int pc);
      return (pc < model_len) ? model_mem[pc] : NOP;
   endfunction

   function automatic logic exp_oor(input int pc);
      return (pc >= model_len);
   endfunction

   // Drives a load of the first n words of load_q, optionally with idle gaps.
   task automatic do_load(input int n, input bit use_last, input bit gaps);
      load_start = 1'b1;
      @(posedge clk); #1;
      load_start = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (gaps && ($urandom_range(0, 3) == 0)) begin
            load_valid = 1'b0;
            @(posedge clk); #1;
         end
         load_valid = 1'b1;
         load_data  = load_q[i];
         load_last  = use_last && (i == n - 1);
         @(posedge clk); #1;
         model_mem[i] = load_q[i];
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
      model_len  = n;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      load_start = 0; load_valid = 0; load_last = 0; load_data = '0;
      req_valid = 0; req_pc = '0; resp_ready = 0;
      #2;
      total++; if (prog_len !== '0)    begin bad++; $display("FAIL reset_prog_len got=%0d exp=0", prog_len); end
      total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL reset_load_ready got=%b exp=0", load_ready); end
      total++; if (state_run !== 1'b0)  begin bad++; $display("FAIL reset_state_run got=%b exp=0", state_run); end
      total++; if (req_ready !== 1'b0)  begin bad++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
      total++; if (resp_valid !== 1'b0 || resp_oor !== 1'b0 || resp_instr !== '0)
         begin bad++; $display("FAIL reset_resp got v=%b o=%b i=%h exp 0/0/0", resp_valid, resp_oor, resp_instr); end
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      req_valid = 1'b1; req_pc = 8'd0; resp_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         total++; if (req_ready !== 1'b0 || state_run !== 1'b0 || resp_valid !== 1'b0)
            begin bad++; $display("FAIL idle_hold got rr=%b run=%b v=%b exp 0/0/0", req_ready, state_run, resp_valid); end
      end
      req_valid = 1'b0;
   endtask

   task automatic test_load();
      logic [DW-1:0] w [4];
      w[0] = 9'h011; w[1] = 9'h022; w[2] = 9'h033; w[3] = 9'h044;
      load_start = 1'b1;
      @(posedge clk); #1;
      load_start = 1'b0;
      total++; if (load_ready !== 1'b1 || prog_len !== '0)
         begin bad++; $display("FAIL load_enter got ready=%b len=%0d exp 1/0", load_ready, prog_len); end
      for (int i = 0; i < 4; i++) begin
         if (i == 2) begin
            load_valid = 1'b0; load_start = 1'b1;
            @(posedge clk); #1;
            load_start = 1'b0;
         end
         load_valid = 1'b1; load_data = w[i]; load_last = (i == 3);
         @(posedge clk); #1;
         model_mem[i] = w[i];
      end
      load_valid = 1'b0; load_last = 1'b0;
      model_len = 4;
      total++; if (prog_len !== 9'd4) begin bad++; $display("FAIL load_prog_len got=%0d exp=4", prog_len); end
      total++; if (state_run !== 1'b1 || load_ready !== 1'b0)
         begin bad++; $display("FAIL load_to_run got run=%b ready=%b exp 1/0", state_run, load_ready); end
   endtask

   task automatic test_back_to_back();
      resp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req_valid = 1'b1; req_pc = AW'(i);
         #1;
         total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL b2b_req_ready pc=%0d got=%b exp=1", i, req_ready); end
         @(posedge clk); #1;
         total++; if (resp_valid !== 1'b1 || resp_instr !== exp_instr(i) || resp_oor !== 1'b0)
            begin bad++; $display("FAIL b2b_resp pc=%0d got v=%b i=%h o=%b exp 1/%h/0", i, resp_valid, resp_instr, resp_oor, exp_instr(i)); end
      end
      req_valid = 1'b0;
      @(posedge clk); #1;
      total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got v=%b exp=0", resp_valid); end
   endtask

   task automatic test_stall();
      req_valid = 1'b1; req_pc = 8'd2; resp_ready = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         req_pc = 8'd1;
         #1;
         total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL stall_req_ready cyc=%0d got=%b exp=0", i, req_ready); end
         total++; if (resp_valid !== 1'b1 || resp_instr !== 9'h033)
            begin bad++; $display("FAIL stall_hold cyc=%0d got v=%b i=%h exp 1/033", i, resp_valid, resp_instr); end
         @(posedge clk); #1;
      end
      resp_ready = 1'b1; req_pc = 8'd3;
      #1;
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL stall_release got=%b exp=1", req_ready); end
      @(posedge clk); #1;
      total++; if (resp_valid !== 1'b1 || resp_instr !== 9'h044)
         begin bad++; $display("FAIL stall_no_bubble got v=%b i=%h exp 1/044", resp_valid, resp_instr); end
      req_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_oor();
      int pcs [3];
      pcs[0] = 7; pcs[1] = 4; pcs[2] = 3;
      resp_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         req_valid = 1'b1; req_pc = AW'(pcs[i]);
         @(posedge clk); #1;
         total++; if (resp_valid !== 1'b1 || resp_instr !== exp_instr(pcs[i]) || resp_oor !== exp_oor(pcs[i]))
            begin bad++; $display("FAIL oor pc=%0d got v=%b i=%h o=%b exp 1/%h/%b", pcs[i], resp_valid, resp_instr, resp_oor, exp_instr(pcs[i]), exp_oor(pcs[i])); end
      end
      req_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reload();
      req_valid = 1'b1; req_pc = 8'd0; resp_ready = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0; load_start = 1'b1;
      @(posedge clk); #1;
      load_start = 1'b0;
      total++; if (resp_valid !== 1'b0 || load_ready !== 1'b1 || state_run !== 1'b0 || prog_len !== '0)
         begin bad++; $display("FAIL reload_discard got v=%b ready=%b run=%b len=%0d exp 0/1/0/0", resp_valid, load_ready, state_run, prog_len); end
      for (int i = 0; i < 4; i++) begin
         load_valid = 1'b1; load_data = model_mem[i]; load_last = (i == 3);
         @(posedge clk); #1;
      end
      load_valid = 1'b0; load_last = 1'b0;
      total++; if (state_run !== 1'b1 || prog_len !== 9'd4)
         begin bad++; $display("FAIL reload_run got run=%b len=%0d exp 1/4", state_run, prog_len); end
      resp_ready = 1'b1;
   endtask

   task automatic test_random();
      logic       exp_v;
      logic [DW-1:0] exp_i;
      logic       exp_o;
      logic       exp_rr;
      int         n, pc;
      for (int rep = 0; rep < 4; rep++) begin
         n = int'($urandom_range(1, 16));
         load_q.delete();
         for (int i = 0; i < n; i++) load_q.push_back(DW'($urandom));
         do_load(n, 1'b1, 1'b1);
         total++; if (prog_len !== 9'(n) || state_run !== 1'b1)
            begin bad++; $display("FAIL rand_load rep=%0d got len=%0d run=%b exp %0d/1", rep, prog_len, state_run, n); end
         exp_v = 1'b0; exp_i = '0; exp_o = 1'b0;
         for (int c = 0; c < 60; c++) begin
            req_valid  = ($urandom_range(0, 3) != 0);
            pc         = int'($urandom_range(0, 31));
            req_pc     = AW'(pc);
            resp_ready = ($urandom_range(0, 2) != 0);
            #1;
            exp_rr = !exp_v || resp_ready;
            total++; if (req_ready !== exp_rr)
               begin bad++; $display("FAIL rand_req_ready rep=%0d cyc=%0d got=%b exp=%b", rep, c, req_ready, exp_rr); end
            @(posedge clk); #1;
            if (req_valid && exp_rr) begin
               exp_v = 1'b1; exp_i = exp_instr(pc); exp_o = exp_oor(pc);
            end else if (resp_ready) begin
               exp_v = 1'b0;
            end
            total++; if (resp_valid !== exp_v || (exp_v && (resp_instr !== exp_i || resp_oor !== exp_o)))
               begin bad++; $display("FAIL rand_resp rep=%0d cyc=%0d got v=%b i=%h o=%b exp %b/%h/%b", rep, c, resp_valid, resp_instr, resp_oor, exp_v, exp_i, exp_o); end
         end
         req_valid = 1'b0; resp_ready = 1'b1;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_full_load();
      load_q.delete();
      for (int i = 0; i < int'(DEPTH); i++) load_q.push_back(DW'($urandom));
      do_load(int'(DEPTH), 1'b0, 1'b0);
      total++; if (state_run !== 1'b1 || load_ready !== 1'b0 || prog_len !== 9'd256)
         begin bad++; $display("FAIL full_load got run=%b ready=%b len=%0d exp 1/0/256", state_run, load_ready, prog_len); end
      resp_ready = 1'b1;
      req_valid = 1'b1; req_pc = 8'd255;
      @(posedge clk); #1;
      total++; if (resp_valid !== 1'b1 || resp_instr !== model_mem[255] || resp_oor !== 1'b0)
         begin bad++; $display("FAIL full_last_word got v=%b i=%h o=%b exp 1/%h/0", resp_valid, resp_instr, resp_oor, model_mem[255]); end
      req_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_load();
      load_start = 1'b1;
      @(posedge clk); #1;
      load_start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         load_valid = 1'b1; load_data = DW'($urandom);
         @(posedge clk); #1;
      end
      total++; if (prog_len !== 9'd2) begin bad++; $display("FAIL midload_count got=%0d exp=2", prog_len); end
      load_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      model_len = 0;
      total++; if (prog_len !== '0 || load_ready !== 1'b0 || state_run !== 1'b0)
         begin bad++; $display("FAIL midload_reset got len=%0d ready=%b run=%b exp 0/0/0", prog_len, load_ready, state_run); end
      @(negedge clk); rst_n = 1'b1;
      req_valid = 1'b1; req_pc = 8'd0;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if (req_ready !== 1'b0 || resp_valid !== 1'b0)
            begin bad++; $display("FAIL midload_fetch cyc=%0d got rr=%b v=%b exp 0/0", i, req_ready, resp_valid); end
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_load();
      test_back_to_back();
      test_stall();
      test_oor();
      test_reload();
      test_random();
      test_full_load();
      test_reset_mid_load();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instr_fetch_mem.md
INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

Interface
REQ-001 Parameter ADDR_WIDTH, default 8: address width; depth is 2**ADDR_WIDTH words.
REQ-002 Parameter DATA_WIDTH, default 9: instruction width.
REQ-003 Parameter NOP_WORD, default 0: value returned for out-of-range fetches.
REQ-004 Clocking SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 load_start  in  1  one-cycle pulse that begins a program load.
REQ-008 load_valid / load_data  in  1 / DATA_WIDTH  load stream word and its qualifier.
REQ-009 load_last  in  1  marks the final word of the load stream.
REQ-010 load_ready  out  1  high only in the LOAD state.
REQ-011 prog_len  out  ADDR_WIDTH+1  number of words loaded.
REQ-012 req_valid / req_pc  in  1 / ADDR_WIDTH  fetch request and its address.
REQ-013 req_ready  out  1  request-accept signal.
REQ-014 resp_valid / resp_instr  out  1 / DATA_WIDTH  fetched instruction and its qualifier.
REQ-015 resp_oor  out  1  high when the fetch address is >= prog_len.
REQ-016 resp_ready  in  1  consumer accepts the response.
REQ-017 state_run  out  1  high in the RUN state.

Function
REQ-018 FSM states SHALL be IDLE, LOAD and RUN.
REQ-019 IDLE or RUN SHALL go to LOAD on load_start.
- In RUN this also clears resp_valid and discards any pending response.
REQ-020 In LOAD, each cycle with load_valid && load_ready SHALL:
- write load_data to mem[wr_ptr];
- increment wr_ptr and prog_len.
REQ-021 wr_ptr and prog_len SHALL clear to 0 when LOAD is entered.
REQ-022 LOAD SHALL go to RUN after an accepted word with load_last set.
REQ-023 LOAD SHALL also go to RUN after the word written at address 2**ADDR_WIDTH-1, even without load_last.
- wr_ptr never wraps; prog_len = 2**ADDR_WIDTH in this case.
REQ-024 load_start during LOAD SHALL be ignored.
REQ-025 req_ready SHALL equal state_run && (!resp_valid || resp_ready).
REQ-026 A request accepted in cycle N SHALL drive resp_valid in cycle N+1 with resp_instr = mem[req_pc].
- If req_pc >= prog_len: resp_instr = NOP_WORD and resp_oor = 1.
REQ-027 resp_valid, resp_instr and resp_oor SHALL hold stable while resp_valid && !resp_ready.
REQ-028 resp_valid SHALL clear in the cycle after a response is consumed with no new request accepted.
- Back-to-back accepted requests SHALL give one response per cycle.
REQ-029 A simultaneous consume and accept SHALL replace the response with no bubble.
REQ-030 Requests outside RUN SHALL be ignored (req_ready = 0).
REQ-031 Memory contents SHALL NOT be cleared by reset.
- Words beyond prog_len SHALL never be observable.

Reset
REQ-032 On rst_n low, asynchronously:
- state = IDLE; wr_ptr, prog_len, resp_valid, resp_oor, resp_instr = 0;
- load_ready, req_ready, state_run = 0.
REQ-033 Reset during LOAD SHALL abandon the load; prog_len reads 0.
REQ-034 After rst_n rises, the block SHALL stay in IDLE until load_start.

Configuration
REQ-035 With IMEM_PARITY_EN defined:
- each word stores an even-parity bit computed at write;
- it is checked on fetch;
- output resp_perr (1 bit) is asserted alongside resp_valid on mismatch;
- resp_perr is forced to 0 for out-of-range fetches.
REQ-036 With IMEM_PARITY_EN undefined, no parity storage and no resp_perr port SHALL exist.

Verification
REQ-037 Load 4 words (0x011, 0x022, 0x033, 0x044 with last on the 4th) -> prog_len = 4, state_run = 1, load_ready = 0 the next cycle.
REQ-038 Fetch pc 0..3 back-to-back with resp_ready = 1 -> responses 0x011..0x044 on consecutive cycles, one cycle after each accept.
REQ-039 Fetch pc 2, hold resp_ready = 0 for 3 cycles -> resp_instr stays 0x033, req_ready = 0; resp_ready = 1 and a new request in the same cycle -> no bubble.
REQ-040 Fetch pc 7 with prog_len = 4 -> resp_instr = NOP_WORD, resp_oor = 1.
REQ-041 Stream 2**ADDR_WIDTH words with no load_last -> enters RUN; prog_len = 256 (default ADDR_WIDTH = 8).
REQ-042 Assert rst_n low mid-load after 2 words -> state IDLE, prog_len = 0; fetch attempts get req_ready = 0.
